// File: rtl/exc_entry_seq.sv
// Exception-entry sequencer: arbitrates FIQ/IRQ/UND/SVC at an instruction boundary and
// strobes the CPSR/SPSR bank through SAVE -> SWITCH -> VECTOR. Optional macro: EXC_IRQ_SYNC_EN.
module exc_entry_seq #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq,
  input  logic        fiq,
  input  logic        und_req,
  input  logic        swi_req,
  input  logic        instr_done,
  input  logic [31:0] CPSR,
  input  logic [31:0] pc_next,
  output logic        Write_SPSR,
  output logic        W_SPSR_s,
  output logic [2:0]  Change_M,
  output logic        Write_CPSR,
  output logic [2:0]  W_CPSR_s,
  output logic        Write_PC,
  output logic [31:0] pc_out,
  output logic        Write_LR,
  output logic [31:0] lr_out,
  output logic        cpu_hold,
  output logic        exc_ack,
  output logic [1:0]  exc_kind
);

  // Handshake: requests are levels sampled only at a boundary (instr_done=1) while idle;
  // exc_ack is a one-cycle completion pulse in the same cycle as the PC/LR strobes.
  typedef enum logic [1:0] {IDLE, SAVE, SWITCH, VECTOR} state_t;

  localparam logic [1:0] K_UND = 2'd0;
  localparam logic [1:0] K_SVC = 2'd1;
  localparam logic [1:0] K_IRQ = 2'd2;
  localparam logic [1:0] K_FIQ = 2'd3;

  state_t      state, state_nxt;
  logic [31:0] pc_lat, pc_lat_nxt;
  logic        fiq_a, irq_a;
  logic        win;
  logic [1:0]  win_kind;

  logic        write_spsr_nxt, w_spsr_s_nxt, write_cpsr_nxt, write_pc_nxt, write_lr_nxt;
  logic        cpu_hold_nxt, exc_ack_nxt;
  logic [2:0]  change_m_nxt, w_cpsr_s_nxt;
  logic [31:0] pc_out_nxt, lr_out_nxt;
  logic [1:0]  exc_kind_nxt;

  logic unused_cpsr;
  assign unused_cpsr = ^{CPSR[31:8], CPSR[5:0]};

`ifdef EXC_IRQ_SYNC_EN
  logic fiq_q1, fiq_q2, irq_q1, irq_q2;
  always_ff @(posedge clk) begin
    if (rst) begin
      fiq_q1 <= 1'b0;
      fiq_q2 <= 1'b0;
      irq_q1 <= 1'b0;
      irq_q2 <= 1'b0;
    end else begin
      fiq_q1 <= fiq;
      fiq_q2 <= fiq_q1;
      irq_q1 <= irq;
      irq_q2 <= irq_q1;
    end
  end
  assign fiq_a = fiq_q2;
  assign irq_a = irq_q2;
`else
  assign fiq_a = fiq;
  assign irq_a = irq;
`endif

  // Masking uses the live CPSR I/F bits at the boundary.
  always_comb begin
    win      = 1'b1;
    win_kind = K_UND;
    if (fiq_a && !CPSR[6])      win_kind = K_FIQ;
    else if (irq_a && !CPSR[7]) win_kind = K_IRQ;
    else if (und_req)           win_kind = K_UND;
    else if (swi_req)           win_kind = K_SVC;
    else                        win      = 1'b0;
  end

  function automatic logic [2:0] mode_code(input logic [1:0] k);
    case (k)
      K_FIQ:   mode_code = 3'd1;
      K_IRQ:   mode_code = 3'd2;
      K_SVC:   mode_code = 3'd3;
      default: mode_code = 3'd4;
    endcase
  endfunction

  function automatic logic [2:0] cpsr_code(input logic [1:0] k);
    case (k)
      K_IRQ:   cpsr_code = 3'd2;
      K_FIQ:   cpsr_code = 3'd3;
      K_SVC:   cpsr_code = 3'd4;
      default: cpsr_code = 3'd5;
    endcase
  endfunction

  function automatic logic [31:0] vec_offset(input logic [1:0] k);
    case (k)
      K_SVC:   vec_offset = 32'h08;
      K_IRQ:   vec_offset = 32'h18;
      K_FIQ:   vec_offset = 32'h1C;
      default: vec_offset = 32'h04;
    endcase
  endfunction

  // Outputs are computed for the state being entered so every strobe is a full registered cycle.
  always_comb begin
    state_nxt      = state;
    pc_lat_nxt     = pc_lat;
    exc_kind_nxt   = exc_kind;
    pc_out_nxt     = pc_out;
    lr_out_nxt     = lr_out;
    write_spsr_nxt = 1'b0;
    w_spsr_s_nxt   = 1'b0;
    change_m_nxt   = 3'd0;
    write_cpsr_nxt = 1'b0;
    w_cpsr_s_nxt   = 3'd0;
    write_pc_nxt   = 1'b0;
    write_lr_nxt   = 1'b0;
    cpu_hold_nxt   = 1'b0;
    exc_ack_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (instr_done && win) begin
          state_nxt      = SAVE;
          exc_kind_nxt   = win_kind;
          pc_lat_nxt     = pc_next;
          write_spsr_nxt = 1'b1;
          w_spsr_s_nxt   = 1'b1;
          change_m_nxt   = mode_code(win_kind);
          cpu_hold_nxt   = 1'b1;
        end
      end
      SAVE: begin
        state_nxt      = SWITCH;
        write_cpsr_nxt = 1'b1;
        w_cpsr_s_nxt   = cpsr_code(exc_kind);
        cpu_hold_nxt   = 1'b1;
      end
      SWITCH: begin
        state_nxt    = VECTOR;
        write_pc_nxt = 1'b1;
        write_lr_nxt = 1'b1;
        exc_ack_nxt  = 1'b1;
        cpu_hold_nxt = 1'b1;
        pc_out_nxt   = VEC_BASE + vec_offset(exc_kind);
        // IRQ/FIQ return past the interrupted instruction; UND/SVC return to pc_next.
        lr_out_nxt   = exc_kind[1] ? pc_lat + 32'd4 : pc_lat;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc_lat     <= 32'd0;
      exc_kind   <= 2'd0;
      pc_out     <= 32'd0;
      lr_out     <= 32'd0;
      Write_SPSR <= 1'b0;
      W_SPSR_s   <= 1'b0;
      Change_M   <= 3'd0;
      Write_CPSR <= 1'b0;
      W_CPSR_s   <= 3'd0;
      Write_PC   <= 1'b0;
      Write_LR   <= 1'b0;
      cpu_hold   <= 1'b0;
      exc_ack    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc_lat     <= pc_lat_nxt;
      exc_kind   <= exc_kind_nxt;
      pc_out     <= pc_out_nxt;
      lr_out     <= lr_out_nxt;
      Write_SPSR <= write_spsr_nxt;
      W_SPSR_s   <= w_spsr_s_nxt;
      Change_M   <= change_m_nxt;
      Write_CPSR <= write_cpsr_nxt;
      W_CPSR_s   <= w_cpsr_s_nxt;
      Write_PC   <= write_pc_nxt;
      Write_LR   <= write_lr_nxt;
      cpu_hold   <= cpu_hold_nxt;
      exc_ack    <= exc_ack_nxt;
    end
  end

endmodule

// File: tb/tb_exc_entry_seq.sv
// Self-checking bench for exc_entry_seq: directed scenarios plus randomized entries
// checked against a table-driven reference model; honours EXC_IRQ_SYNC_EN.
module tb_exc_entry_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq = 1'b0, fiq = 1'b0, und_req = 1'b0, swi_req = 1'b0, instr_done = 1'b0;
  logic [31:0] CPSR = 32'd0, pc_next = 32'd0;
  logic        Write_SPSR, W_SPSR_s, Write_CPSR, Write_PC, Write_LR, cpu_hold, exc_ack;
  logic [2:0]  Change_M, W_CPSR_s;
  logic [31:0] pc_out, lr_out;
  logic [1:0]  exc_kind;

  localparam logic [31:0] VB = 32'h0000_0000;

  exc_entry_seq #(.VEC_BASE(VB)) dut (
    .clk(clk), .rst(rst), .irq(irq), .fiq(fiq), .und_req(und_req), .swi_req(swi_req),
    .instr_done(instr_done), .CPSR(CPSR), .pc_next(pc_next),
    .Write_SPSR(Write_SPSR), .W_SPSR_s(W_SPSR_s), .Change_M(Change_M),
    .Write_CPSR(Write_CPSR), .W_CPSR_s(W_CPSR_s), .Write_PC(Write_PC), .pc_out(pc_out),
    .Write_LR(Write_LR), .lr_out(lr_out), .cpu_hold(cpu_hold), .exc_ack(exc_ack),
    .exc_kind(exc_kind)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference tables indexed by kind (0 und, 1 svc, 2 irq, 3 fiq).
  localparam logic [2:0]  M_CODE[4] = '{3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [2:0]  W_CODE[4] = '{3'd5, 3'd4, 3'd2, 3'd3};
  localparam logic [31:0] OFF[4]    = '{32'h04, 32'h08, 32'h18, 32'h1C};

  logic [65:0] exp_q[$];
  logic [65:0] exp_item;
  logic        irq_h0 = 1'b0, irq_h1 = 1'b0, fiq_h0 = 1'b0, fiq_h1 = 1'b0;

  logic [12:0] obs;
  assign obs = {Write_SPSR, W_SPSR_s, Change_M, Write_CPSR, W_CPSR_s,
                Write_PC, Write_LR, cpu_hold, exc_ack};

  // Advance one edge, tracking what a two-flop synchronizer would hold.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      irq_h0 = 1'b0; irq_h1 = 1'b0; fiq_h0 = 1'b0; fiq_h1 = 1'b0;
    end else begin
      irq_h1 = irq_h0; irq_h0 = irq; fiq_h1 = fiq_h0; fiq_h0 = fiq;
    end
    #1;
  endtask

  function automatic logic eff_fiq();
`ifdef EXC_IRQ_SYNC_EN
    return fiq_h1;
`else
    return fiq;
`endif
  endfunction

  function automatic logic eff_irq();
`ifdef EXC_IRQ_SYNC_EN
    return irq_h1;
`else
    return irq;
`endif
  endfunction

  // Winning kind at a boundary, or -1 when nothing is taken.
  function automatic int winner(input logic f, input logic i, input logic u, input logic s,
                                input logic [31:0] c);
    if (f && !c[6]) return 3;
    if (i && !c[7]) return 2;
    if (u) return 0;
    if (s) return 1;
    return -1;
  endfunction

  function automatic logic [12:0] exp_vec(input int phase, input logic [1:0] k);
    case (phase)
      1:       return {1'b1, 1'b1, M_CODE[k], 1'b0, 3'd0, 4'b0010};
      2:       return {1'b0, 1'b0, 3'd0, 1'b1, W_CODE[k], 4'b0010};
      3:       return {1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 4'b1111};
      default: return 13'd0;
    endcase
  endfunction

  function automatic logic [65:0] exp_entry(input logic [1:0] k, input logic [31:0] pcn);
    return {k, VB + OFF[k], (k >= 2'd2) ? pcn + 32'd4 : pcn};
  endfunction

  task automatic clear_inputs();
    irq = 0; fiq = 0; und_req = 0; swi_req = 0; instr_done = 0; CPSR = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick(); tick();
    checks++;
    if (obs !== 13'd0 || pc_out !== 32'd0 || lr_out !== 32'd0 || exc_kind !== 2'd0) begin
      errors++;
      $display("FAIL reset: obs=%h pc=%h lr=%h kind=%0d, want all 0", obs, pc_out, lr_out, exc_kind);
    end
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (obs !== 13'd0) begin
        errors++;
        $display("FAIL idle_after_reset: obs=%h want 0", obs);
      end
    end
  endtask

  task automatic test_svc();
    clear_inputs();
    swi_req = 1; pc_next = 32'h100; instr_done = 1;
    tick();
    instr_done = 0;
    for (int p = 1; p <= 3; p++) begin
      if (p > 1) tick();
      checks++;
      if (obs !== exp_vec(p, 2'd1)) begin
        errors++;
        $display("FAIL svc_phase%0d: obs=%h want %h", p, obs, exp_vec(p, 2'd1));
      end
    end
    checks++;
    if (pc_out !== 32'h08 || lr_out !== 32'h100 || exc_kind !== 2'd1) begin
      errors++;
      $display("FAIL svc_vector: pc=%h lr=%h kind=%0d want 08 100 1", pc_out, lr_out, exc_kind);
    end
    swi_req = 0;
    tick();
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL svc_return_idle: obs=%h want 0", obs);
    end
  endtask

  task automatic test_priority();
    clear_inputs();
    fiq = 1; irq = 1; swi_req = 1; pc_next = 32'h200;
    tick(); tick(); tick();
    instr_done = 1;
    tick();
    fiq = 0; irq = 0; instr_done = 0;
    for (int p = 1; p <= 3; p++) begin
      if (p > 1) tick();
      checks++;
      if (obs !== exp_vec(p, 2'd3)) begin
        errors++;
        $display("FAIL prio_fiq_phase%0d: obs=%h want %h", p, obs, exp_vec(p, 2'd3));
      end
    end
    checks++;
    if (pc_out !== 32'h1C || lr_out !== 32'h204 || exc_kind !== 2'd3) begin
      errors++;
      $display("FAIL prio_fiq_vector: pc=%h lr=%h kind=%0d want 1c 204 3", pc_out, lr_out, exc_kind);
    end
    tick();
    instr_done = 1;
    pc_next = 32'h208;
    tick();
    instr_done = 0;
    for (int p = 1; p <= 3; p++) begin
      if (p > 1) tick();
      checks++;
      if (obs !== exp_vec(p, 2'd1)) begin
        errors++;
        $display("FAIL prio_svc_phase%0d: obs=%h want %h", p, obs, exp_vec(p, 2'd1));
      end
    end
    checks++;
    if (pc_out !== 32'h08 || lr_out !== 32'h208 || exc_kind !== 2'd1) begin
      errors++;
      $display("FAIL prio_svc_vector: pc=%h lr=%h kind=%0d want 08 208 1", pc_out, lr_out, exc_kind);
    end
    swi_req = 0;
    tick();
  endtask

  task automatic test_masking();
    logic [31:0] pcn;
    clear_inputs();
    CPSR = 32'h80; irq = 1; instr_done = 1;
    for (int n = 0; n < 20; n++) begin
      tick();
      checks++;
      if (cpu_hold !== 1'b0) begin
        errors++;
        $display("FAIL mask_irq: cpu_hold=%b want 0", cpu_hold);
      end
    end
    pcn = $urandom;
    pc_next = pcn;
    CPSR = 32'h0;
    tick();
    irq = 0; instr_done = 0;
    for (int p = 1; p <= 3; p++) begin
      if (p > 1) tick();
      checks++;
      if (obs !== exp_vec(p, 2'd2)) begin
        errors++;
        $display("FAIL unmask_irq_phase%0d: obs=%h want %h", p, obs, exp_vec(p, 2'd2));
      end
    end
    checks++;
    if (pc_out !== 32'h18 || lr_out !== pcn + 32'd4 || exc_kind !== 2'd2) begin
      errors++;
      $display("FAIL unmask_irq_vector: pc=%h lr=%h kind=%0d want 18 %h 2", pc_out, lr_out, exc_kind, pcn + 32'd4);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    und_req = 1; pc_next = 32'h300; instr_done = 1;
    tick();
    instr_done = 0;
    tick();
    checks++;
    if (obs !== exp_vec(2, 2'd0)) begin
      errors++;
      $display("FAIL rstmid_switch: obs=%h want %h", obs, exp_vec(2, 2'd0));
    end
    rst = 1;
    tick();
    checks++;
    if (obs !== 13'd0 || exc_kind !== 2'd0 || pc_out !== 32'd0 || lr_out !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_abort: obs=%h kind=%0d pc=%h lr=%h want 0", obs, exc_kind, pc_out, lr_out);
    end
    rst = 0;
    tick();
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL rstmid_idle: obs=%h want 0", obs);
    end
    pc_next = 32'h400; instr_done = 1;
    tick();
    instr_done = 0;
    for (int p = 1; p <= 3; p++) begin
      if (p > 1) tick();
      checks++;
      if (obs !== exp_vec(p, 2'd0)) begin
        errors++;
        $display("FAIL rstmid_und_phase%0d: obs=%h want %h", p, obs, exp_vec(p, 2'd0));
      end
    end
    checks++;
    if (pc_out !== 32'h04 || lr_out !== 32'h400 || exc_kind !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_und_vector: pc=%h lr=%h kind=%0d want 04 400 0", pc_out, lr_out, exc_kind);
    end
    und_req = 0;
    tick();
  endtask

  task automatic test_sync();
    int lat, want;
    clear_inputs();
    tick(); tick(); tick(); tick();
`ifdef EXC_IRQ_SYNC_EN
    want = 3;
`else
    want = 1;
`endif
    irq = 1; instr_done = 1;
    lat = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      lat++;
      if (cpu_hold) break;
    end
    checks++;
    if (lat !== want || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL irq_latency: edges=%0d hold=%b want %0d", lat, cpu_hold, want);
    end
    irq = 0; instr_done = 0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic randomize_inputs();
    fiq = ($urandom_range(0, 3) == 0);
    irq = ($urandom_range(0, 2) == 0);
    case ($urandom_range(0, 2))
      0:       begin und_req = 1; swi_req = 0; end
      1:       begin und_req = 0; swi_req = 1; end
      default: begin und_req = 0; swi_req = 0; end
    endcase
    instr_done = $urandom_range(0, 1);
    CPSR = {24'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
    pc_next = (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom);
  endtask

  task automatic test_random();
    int w;
    logic [1:0] k;
    for (int it = 0; it < 120; it++) begin
      randomize_inputs();
      w = instr_done ? winner(eff_fiq(), eff_irq(), und_req, swi_req, CPSR) : -1;
      if (w >= 0) exp_q.push_back(exp_entry(2'(w), pc_next));
      tick();
      if (w < 0) begin
        checks++;
        if (obs !== 13'd0) begin
          errors++;
          $display("FAIL rand_no_entry: obs=%h want 0", obs);
        end
      end else begin
        k = 2'(w);
        for (int p = 1; p <= 3; p++) begin
          if (p > 1) begin
            randomize_inputs();
            tick();
          end
          checks++;
          if (obs !== exp_vec(p, k)) begin
            errors++;
            $display("FAIL rand_phase%0d kind%0d: obs=%h want %h", p, k, obs, exp_vec(p, k));
          end
        end
        exp_item = exp_q.pop_front();
        checks++;
        if ({exc_kind, pc_out, lr_out} !== exp_item) begin
          errors++;
          $display("FAIL rand_vector: kind/pc/lr=%h want %h", {exc_kind, pc_out, lr_out}, exp_item);
        end
        randomize_inputs();
        tick();
        checks++;
        if (obs !== 13'd0) begin
          errors++;
          $display("FAIL rand_back_to_idle: obs=%h want 0", obs);
        end
      end
    end
    clear_inputs();
    tick(); tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_svc();
    test_priority();
    test_masking();
    test_reset_mid();
    test_sync();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exc_entry_seq.md
# exc_entry_seq

Exception-entry sequencer. It sits directly upstream of the CPSR/SPSR register bank and drives that bank's write controls. At an instruction boundary it arbitrates pending FIQ, IRQ, undefined-instruction and SVC requests. It then runs a fixed three-step entry sequence: save CPSR to the target-mode SPSR, switch the CPSR mode and mask bits, then load the vector into PC and the return address into LR. The core is held for the duration of the sequence.

## Interface
Parameters:
- VEC_BASE, 32'h0000_0000, base address added to every exception vector offset

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- irq  in  1  level-sensitive IRQ request from the peripheral side
- fiq  in  1  level-sensitive FIQ request
- und_req  in  1  undefined-instruction request from decode; held high until exc_ack
- swi_req  in  1  SVC request from decode; held high until exc_ack; never high together with und_req
- instr_done  in  1  current instruction retires this cycle (boundary)
- CPSR  in  32  current CPSR from the register bank (bit 7 = I, bit 6 = F)
- pc_next  in  32  address of the instruction following the retiring one
- Write_SPSR  out  1  SPSR write strobe to the register bank
- W_SPSR_s  out  1  SPSR source select; 1 = capture CPSR
- Change_M  out  3  mode override for SPSR bank select: 0 none, 1 fiq, 2 irq, 3 svc, 4 und
- Write_CPSR  out  1  CPSR write strobe
- W_CPSR_s  out  3  CPSR source code: 2 irq, 3 fiq, 4 svc, 5 und
- Write_PC  out  1  PC load strobe
- pc_out  out  32  vector address
- Write_LR  out  1  banked LR write strobe
- lr_out  out  32  return address
- cpu_hold  out  1  stall fetch/decode/execute
- exc_ack  out  1  one-cycle pulse; entry finished
- exc_kind  out  2  latched kind: 0 und, 1 svc, 2 irq, 3 fiq

## Operation
- FSM states: IDLE, SAVE, SWITCH, VECTOR.
- **IDLE, arbitration.** Arbitration happens only when instr_done=1.
  - Priority order: fiq & ~CPSR[6], then irq & ~CPSR[7], then und_req, then swi_req.
  - The winner is latched into exc_kind and the FSM moves to SAVE. With no winner, the FSM stays in IDLE.
- **SAVE.** Write_SPSR=1, W_SPSR_s=1, Change_M = code for exc_kind. All other strobes are 0. Next state SWITCH.
- **SWITCH.** Write_CPSR=1, W_CPSR_s = code for exc_kind, Change_M=0. Next state VECTOR.
- **VECTOR.** Write_PC=1, Write_LR=1, exc_ack=1. Next state IDLE.
  - pc_out = VEC_BASE + offset. Offsets: und 0x04, svc 0x08, irq 0x18, fiq 0x1C.
  - lr_out = pc_next_latched + 4 for irq/fiq; pc_next_latched for und/svc. Addition is modulo 2^32 with wrap and no flag.
- pc_next is latched on the IDLE→SAVE transition and used unchanged for the rest of the sequence.
- cpu_hold=1 in SAVE, SWITCH and VECTOR.
- A request that loses arbitration is not recorded.
  - und_req/swi_req stay held by decode and are re-arbitrated at the next boundary.
  - irq/fiq are re-sampled as levels at the next boundary.
- Requests arriving while not in IDLE are ignored.
- Masking uses the live CPSR at the boundary. After SWITCH, the new I/F bits mask nested requests automatically.

## Timing
- Reset: state IDLE. exc_kind=0, pc_out=0, lr_out=0. All strobes, Change_M, W_CPSR_s, W_SPSR_s, cpu_hold and exc_ack are 0.
- Reset asserted mid-sequence aborts it at the next rising edge with the reset values above. No partial write is strobed after that edge.
- All outputs are registered and each strobe is high for exactly one full clock cycle. The register bank's falling-edge capture therefore lands mid-cycle with stable data and selects.
- Latency, counted from the rising edge that samples instr_done with a winner (edge 0):
  - SAVE in cycle 1, SWITCH in cycle 2, VECTOR in cycle 3, IDLE in cycle 4.
  - Earliest next arbitration is at the edge ending cycle 4.
- Ordering guarantee: the SPSR write (cycle 1) always precedes the CPSR mode change (cycle 2). Change_M is stable for the whole of cycle 1.
- Simultaneous fiq, irq and swi_req at a boundary: fiq is taken; swi_req remains pending.

## Configuration
- EXC_IRQ_SYNC_EN defined: irq and fiq each pass through a two-flop synchronizer, reset to 0, before arbitration. This adds 2 cycles of request-to-sample latency.
- Not defined: irq and fiq are used directly, with no added latency.

## Test plan
- **Reset and idle.** rst=1 for 2 cycles, then idle inputs → all outputs 0, cpu_hold=0, FSM idle for 10 cycles.
- **SVC entry.** swi_req=1, instr_done=1, pc_next=0x100 → cycle 1: Write_SPSR=1, W_SPSR_s=1, Change_M=3. Cycle 2: Write_CPSR=1, W_CPSR_s=4. Cycle 3: pc_out=0x08, lr_out=0x100, exc_ack=1, exc_kind=1.
- **Priority.** fiq=irq=swi_req=1, CPSR[7:6]=00, pc_next=0x200 → Change_M=1, W_CPSR_s=3, pc_out=0x1C, lr_out=0x204. At the next boundary swi_req is taken.
- **Masking.** irq=1, CPSR[7]=1 → no entry for 20 cycles. Clear CPSR[7] → IRQ entry with pc_out=0x18, lr_out=pc_next+4.
- **Reset mid-sequence.** rst=1 during SWITCH → next cycle all strobes 0 and state IDLE. After deassert, held und_req re-enters with pc_out=0x04.
- **Synchronizer.** With EXC_IRQ_SYNC_EN defined, an irq rise is taken no earlier than 2 cycles after the unsynchronized build would take it. Without the macro, it is taken at the first boundary.
